// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared sprite/tile constants, FSM encoding and tile-to-pixel helpers.
// Used by the sprite draw scheduler and its round-robin arbiter.
package pacman_defs;

    localparam int TILE_W     = 5;
    localparam int SHAPE_W    = 25;
    localparam int X_TILE_MAX = 26;
    localparam int Y_TILE_MAX = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ERASE,
        ST_DRAW,
        ST_DONE
    } state_e;

    // tile*5 as shift-and-add
    function automatic logic [7:0] tile_px_x(input logic [7:0] t);
        return (t << 2) + t;
    endfunction

    function automatic logic [6:0] tile_px_y(input logic [6:0] t);
        return (t << 2) + t;
    endfunction

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i and wraps.
// Produces a one-hot grant, the winner index and a valid flag.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid_o && req_i[(int'(ptr_i) + k) % N]) begin
                valid_o = 1'b1;
                idx_o   = IW'((int'(ptr_i) + k) % N);
                gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Serialises sprite moves from NUM_REQ movers into VGA pixel writes (erase, then draw).
// Optional SPRITE_TRANSPARENT_EN: shape-0 pixels are not plotted during DRAW.
module sprite_draw_scheduler
    import pacman_defs::*;
#(
    parameter int                  NUM_REQ   = 4,
    parameter int                  COLOUR_W  = 3,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*SHAPE_W-1:0]   req_shape,
    input  logic [NUM_REQ*8-1:0]         req_x_old,
    input  logic [NUM_REQ*7-1:0]         req_y_old,
    input  logic [NUM_REQ*8-1:0]         req_x_new,
    input  logic [NUM_REQ*7-1:0]         req_y_new,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         busy,
    output logic [7:0]                   vga_x,
    output logic [6:0]                   vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         vga_plot
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d, id_q, id_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d, ack_q, ack_d;
    logic [SHAPE_W-1:0]   shape_q, shape_d;
    logic [COLOUR_W-1:0]  colour_q, colour_d, vc_q, vc_d;
    logic [7:0]           ox_q, ox_d, nx_q, nx_d, vx_q, vx_d;
    logic [6:0]           oy_q, oy_d, ny_q, ny_d, vy_q, vy_d;
    logic [2:0]           row_q, row_d, col_q, col_d;
    logic                 plot_q, plot_d;

    logic [NUM_REQ-1:0]   win_gnt;
    logic [IW-1:0]        win_idx;
    logic                 win_valid;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (win_gnt),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    logic [SHAPE_W-1:0]  w_shape;
    logic [COLOUR_W-1:0] w_col;
    logic [7:0]          w_xo, w_xn;
    logic [6:0]          w_yo, w_yn;
    logic                w_oob, w_same;

    assign w_shape = req_shape[win_idx*SHAPE_W +: SHAPE_W];
    assign w_col   = req_colour[win_idx*COLOUR_W +: COLOUR_W];
    assign w_xo    = req_x_old[win_idx*8 +: 8];
    assign w_xn    = req_x_new[win_idx*8 +: 8];
    assign w_yo    = req_y_old[win_idx*7 +: 7];
    assign w_yn    = req_y_new[win_idx*7 +: 7];
    assign w_oob   = (w_xo > 8'(X_TILE_MAX)) || (w_xn > 8'(X_TILE_MAX))
                  || (w_yo > 7'(Y_TILE_MAX)) || (w_yn > 7'(Y_TILE_MAX));
    assign w_same  = (w_xo == w_xn) && (w_yo == w_yn);

    // Row/column walk of the 5x5 tile replaces p/5 and p%5
    logic       col_end, last;
    logic [2:0] row_nx, col_nx;

    assign col_end = (col_q == 3'(TILE_W - 1));
    assign last    = col_end && (row_q == 3'(TILE_W - 1));
    assign col_nx  = col_end ? 3'd0 : col_q + 3'd1;
    assign row_nx  = last ? 3'd0 : (col_end ? row_q + 3'd1 : row_q);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        gnt_d    = gnt_q;
        shape_d  = shape_q;
        colour_d = colour_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        row_d    = row_q;
        col_d    = col_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        vc_d     = vc_q;
        plot_d   = 1'b0;
        ack_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (win_valid) begin
                    id_d     = win_idx;
                    gnt_d    = win_gnt;
                    shape_d  = w_shape;
                    colour_d = w_col;
                    ox_d     = tile_px_x(w_xo);
                    oy_d     = tile_px_y(w_yo);
                    nx_d     = tile_px_x(w_xn);
                    ny_d     = tile_px_y(w_yn);
                    row_d    = '0;
                    col_d    = '0;
                    if (w_oob)       state_d = ST_DONE;
                    else if (w_same) state_d = ST_DRAW;
                    else             state_d = ST_ERASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERASE: begin
                plot_d = 1'b1;
                vx_d   = ox_q + {5'd0, col_q};
                vy_d   = oy_q + {4'd0, row_q};
                vc_d   = BG_COLOUR;
                row_d  = row_nx;
                col_d  = col_nx;
                if (last) state_d = ST_DRAW;
            end
            ST_DRAW: begin
`ifdef SPRITE_TRANSPARENT_EN
                plot_d = shape_q[SHAPE_W-1];
`else
                plot_d = 1'b1;
`endif
                vx_d    = nx_q + {5'd0, col_q};
                vy_d    = ny_q + {4'd0, row_q};
                vc_d    = shape_q[SHAPE_W-1] ? colour_q : BG_COLOUR;
                shape_d = shape_q << 1;
                row_d   = row_nx;
                col_d   = col_nx;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                ack_d   = gnt_q;
                ptr_d   = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            gnt_q    <= '0;
            shape_q  <= '0;
            colour_q <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            nx_q     <= '0;
            ny_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            vc_q     <= '0;
            plot_q   <= 1'b0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            gnt_q    <= gnt_d;
            shape_q  <= shape_d;
            colour_q <= colour_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            row_q    <= row_d;
            col_q    <= col_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            vc_q     <= vc_d;
            plot_q   <= plot_d;
            ack_q    <= ack_d;
        end
    end

    assign ack        = ack_q;
    assign busy       = (state_q != ST_IDLE);
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;
    assign vga_plot   = plot_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: directed and random moves against a
// transaction-level model of expected plots and ack timing.
module tb_sprite_draw_scheduler;

    localparam int NR = 4;
    localparam int CW = 3;
    localparam logic [CW-1:0] BG = 3'b000;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*25-1:0]  req_shape = '0;
    logic [NR*8-1:0]   req_x_old = '0;
    logic [NR*7-1:0]   req_y_old = '0;
    logic [NR*8-1:0]   req_x_new = '0;
    logic [NR*7-1:0]   req_y_new = '0;
    logic [NR*CW-1:0]  req_colour = '0;
    logic [NR-1:0]     ack;
    logic              busy;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [CW-1:0]     vga_colour;
    logic              vga_plot;

    sprite_draw_scheduler #(
        .NUM_REQ   (NR),
        .COLOUR_W  (CW),
        .BG_COLOUR (BG)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_shape  (req_shape),
        .req_x_old  (req_x_old),
        .req_y_old  (req_y_old),
        .req_x_new  (req_x_new),
        .req_y_new  (req_y_new),
        .req_colour (req_colour),
        .ack        (ack),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int cyc;
        int x;
        int y;
        int c;
    } plot_t;

    plot_t exp_q[$];
    plot_t act_q[$];

    task automatic set_fields(input int id, input logic [24:0] sh,
                              input logic [CW-1:0] col,
                              input int xo, input int yo,
                              input int xn, input int yn);
        req_shape[id*25 +: 25]   = sh;
        req_colour[id*CW +: CW]  = col;
        req_x_old[id*8 +: 8]     = 8'(xo);
        req_y_old[id*7 +: 7]     = 7'(yo);
        req_x_new[id*8 +: 8]     = 8'(xn);
        req_y_new[id*7 +: 7]     = 7'(yn);
    endtask

    // Expected pixel stream for a move whose request is seen in IDLE at cycle n
    task automatic expect_move(input int n, input logic [24:0] sh,
                               input logic [CW-1:0] col,
                               input int xo, input int yo,
                               input int xn, input int yn,
                               output int ack_cyc);
        plot_t e;
        int base;
        logic b;
        exp_q = {};
        if (xo > 26 || xn > 26 || yo > 23 || yn > 23) begin
            ack_cyc = n + 3;
        end else begin
            base = n + 3;
            if (!(xo == xn && yo == yn)) begin
                for (int p = 0; p < 25; p++) begin
                    e.cyc = base + p;
                    e.x = xo * 5 + p % 5;
                    e.y = yo * 5 + p / 5;
                    e.c = int'(BG);
                    exp_q.push_back(e);
                end
                base += 25;
            end
            for (int p = 0; p < 25; p++) begin
                b = sh[24 - p];
`ifdef SPRITE_TRANSPARENT_EN
                if (b) begin
`else
                begin
`endif
                    e.cyc = base + p;
                    e.x = xn * 5 + p % 5;
                    e.y = yn * 5 + p / 5;
                    e.c = b ? int'(col) : int'(BG);
                    exp_q.push_back(e);
                end
            end
            ack_cyc = base + 25;
        end
    endtask

    task automatic run_move(input string name, input int id,
                            input logic [24:0] sh, input logic [CW-1:0] col,
                            input int xo, input int yo,
                            input int xn, input int yn,
                            input bit scramble);
        int n;
        int ack_cyc;
        int a_cyc;
        int bad;
        bit got;
        logic [NR-1:0] a_val;
        logic [NR-1:0] oh;
        plot_t e;
        for (int i = 0; i < 100 && busy; i++) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_wait: busy=%b want 0", name, busy);
        end
        set_fields(id, sh, col, xo, yo, xn, yn);
        req = '0;
        req[id] = 1'b1;
        n = cyc;
        expect_move(n, sh, col, xo, yo, xn, yn, ack_cyc);
        act_q = {};
        got = 0;
        a_cyc = 0;
        a_val = '0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clock);
            if (scramble && cyc == n + 2) begin
                req[id] = 1'b0;
                set_fields(id, 25'($urandom), CW'($urandom),
                           $urandom_range(0, 30), $urandom_range(0, 30),
                           $urandom_range(0, 30), $urandom_range(0, 30));
            end
            if (vga_plot) begin
                e.cyc = cyc;
                e.x = int'(vga_x);
                e.y = int'(vga_y);
                e.c = int'(vga_colour);
                act_q.push_back(e);
            end
            if (ack != '0) begin
                got = 1;
                a_cyc = cyc;
                a_val = ack;
                req[id] = 1'b0;
            end
        end
        oh = '0;
        oh[id] = 1'b1;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s ack_timeout: no ack, want at cycle %0d", name, ack_cyc);
        end else begin
            checks++;
            if (a_cyc !== ack_cyc) begin
                failures++;
                $display("FAIL %s ack_cycle: got %0d want %0d (req at %0d)",
                         name, a_cyc, ack_cyc, n);
            end
            checks++;
            if (a_val !== oh) begin
                failures++;
                $display("FAIL %s ack_value: got %b want %b", name, a_val, oh);
            end
        end
        checks++;
        if (act_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s plot_count: got %0d want %0d",
                     name, act_q.size(), exp_q.size());
        end
        bad = -1;
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            if (bad < 0 && (act_q[i].cyc != exp_q[i].cyc || act_q[i].x != exp_q[i].x
                || act_q[i].y != exp_q[i].y || act_q[i].c != exp_q[i].c))
                bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s plot[%0d]: got cyc=%0d x=%0d y=%0d c=%0d want cyc=%0d x=%0d y=%0d c=%0d",
                     name, bad, act_q[bad].cyc, act_q[bad].x, act_q[bad].y, act_q[bad].c,
                     exp_q[bad].cyc, exp_q[bad].x, exp_q[bad].y, exp_q[bad].c);
        end
        @(negedge clock);
        checks++;
        if (ack !== '0 || vga_plot !== 1'b0) begin
            failures++;
            $display("FAIL %s ack_width: ack=%b plot=%b want 0/0", name, ack, vga_plot);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (vga_plot !== 1'b0 || busy !== 1'b0 || ack !== '0 || vga_x !== 8'd0
            || vga_y !== 7'd0 || vga_colour !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: plot=%b busy=%b ack=%b x=%0d y=%0d c=%0d want all 0",
                     vga_plot, busy, ack, vga_x, vga_y, vga_colour);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || vga_plot !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: busy=%b plot=%b want 0/0", busy, vga_plot);
        end
    endtask

    task automatic test_reset_mid_draw();
        set_fields(2, '1, 3'b101, 1, 1, 2, 2);
        req = '0;
        req[2] = 1'b1;
        repeat (35) @(negedge clock);
        checks++;
        if (vga_plot !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_draw_active: plot=%b busy=%b want 1/1", vga_plot, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (vga_plot !== 1'b0 || busy !== 1'b0 || ack !== '0) begin
            failures++;
            $display("FAIL async_reset: plot=%b busy=%b ack=%b want 0/0/0",
                     vga_plot, busy, ack);
        end
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // All four held high: acks must rotate 0,1,2,3,0 at 28-cycle spacing
    task automatic test_round_robin();
        int got = 0;
        int n;
        logic [NR-1:0] prev = '0;
        logic [NR-1:0] oh;
        for (int id = 0; id < NR; id++)
            set_fields(id, 25'($urandom), CW'($urandom), 7, 8, 7, 8);
        req = '1;
        n = cyc;
        for (int i = 0; i < 400 && got < 5; i++) begin
            @(negedge clock);
            if (ack != '0) begin
                oh = '0;
                oh[got % NR] = 1'b1;
                checks++;
                if (ack !== oh) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got %b want %b", got, ack, oh);
                end
                checks++;
                if (cyc != n + 28 * (got + 1)) begin
                    failures++;
                    $display("FAIL rr_ack_cycle[%0d]: got %0d want %0d",
                             got, cyc, n + 28 * (got + 1));
                end
                checks++;
                if (prev !== '0) begin
                    failures++;
                    $display("FAIL rr_ack_width[%0d]: prev ack %b want 0", got, prev);
                end
                got++;
                if (got == 5) req = '0;
            end
            prev = ack;
        end
        checks++;
        if (got != 5) begin
            failures++;
            $display("FAIL rr_timeout: got %0d acks want 5", got);
        end
        @(negedge clock);
        checks++;
        if (ack !== '0) begin
            failures++;
            $display("FAIL rr_last_ack_width: ack=%b want 0", ack);
        end
    endtask

    task automatic test_directed();
        run_move("basic", 0, '1, 3'b110, 0, 0, 1, 0, 0);
        run_move("same_tile_max", 1, 25'h1A5_5A5A, 3'b011, 26, 23, 26, 23, 0);
        run_move("oob_new_x", 2, '1, 3'b111, 3, 3, 27, 3, 0);
        run_move("oob_old_y", 3, '1, 3'b010, 0, 24, 0, 0, 0);
        run_move("shape_lsb", 3, 25'h1, 3'b011, 3, 4, 5, 6, 0);
        run_move("scrambled", 1, 25'h0F0_F0F0, 3'b100, 10, 2, 11, 3, 1);
    endtask

    task automatic test_random();
        int id, xo, yo, xn, yn, r, w;
        string nm;
        for (int k = 0; k < 20; k++) begin
            id = $urandom_range(0, NR - 1);
            xo = $urandom_range(0, 26);
            yo = $urandom_range(0, 23);
            xn = $urandom_range(0, 26);
            yn = $urandom_range(0, 23);
            r = $urandom_range(0, 9);
            if (r < 2) begin
                xn = xo;
                yn = yo;
            end else if (r == 2) begin
                w = $urandom_range(0, 3);
                case (w)
                    0: xo = $urandom_range(27, 255);
                    1: yo = $urandom_range(24, 127);
                    2: xn = $urandom_range(27, 255);
                    default: yn = $urandom_range(24, 127);
                endcase
            end
            nm = $sformatf("rand%0d", k);
            run_move(nm, id, 25'($urandom), CW'($urandom), xo, yo, xn, yn,
                     1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_mid_draw();
        test_round_robin();
        test_directed();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
